// File: rtl/seg_digit_scanner.sv
// Four-digit seven-segment scanner: rotates one nibble and its active-low anode every REFRESH_DIV cycles.
// Loads are double-buffered and reach the display at the next frame boundary (1 to 4*REFRESH_DIV cycles later).
module seg_digit_scanner #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [15:0] value_i,
  input  logic        lzb_en_i,
  output logic [3:0]  nibble_o,
  output logic [3:0]  anode_n_o,
  output logic        frame_tick_o
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] DIV_MAX = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]    dig_sel_q, dig_sel_d;
  logic [15:0]   shadow_q, shadow_d;
  logic          pending_q, pending_d;
  logic [15:0]   shown_q, shown_d;
  logic          tick;
  logic          blank;

  assign tick         = (div_cnt_q == DIV_MAX);
  assign frame_tick_o = tick && (dig_sel_q == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      dig_sel_q <= 2'd0;
      shadow_q  <= 16'h0;
      pending_q <= 1'b0;
      shown_q   <= 16'h0;
    end else begin
      div_cnt_q <= div_cnt_d;
      dig_sel_q <= dig_sel_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      shown_q   <= shown_d;
    end
  end

  always_comb begin
    div_cnt_d = tick ? '0 : div_cnt_q + CW'(1);
    dig_sel_d = tick ? dig_sel_q + 2'd1 : dig_sel_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    shown_d   = shown_q;
    if (frame_tick_o && pending_q) begin
      shown_d   = shadow_q;
      pending_d = 1'b0;
    end
    // A load on the boundary cycle re-arms pending so it lands one frame later.
    if (load_i) begin
      shadow_d  = value_i;
      pending_d = 1'b1;
    end
  end

  always_comb begin
    blank = 1'b0;
    if (lzb_en_i) begin
      case (dig_sel_q)
        2'd1:    blank = (shown_q[15:4]  == 12'h0);
        2'd2:    blank = (shown_q[15:8]  == 8'h0);
        2'd3:    blank = (shown_q[15:12] == 4'h0);
        default: blank = 1'b0;
      endcase
    end
  end

  always_comb begin
    case (dig_sel_q)
      2'd0:    nibble_o = shown_q[3:0];
      2'd1:    nibble_o = shown_q[7:4];
      2'd2:    nibble_o = shown_q[11:8];
      default: nibble_o = shown_q[15:12];
    endcase
    anode_n_o = blank ? 4'b1111 : ~(4'b0001 << dig_sel_q);
  end

endmodule

// File: tb/tb_seg_digit_scanner.sv
// Directed bench for seg_digit_scanner with REFRESH_DIV = 4; per-cycle expectations go through a scoreboard queue.
module tb_seg_digit_scanner;

  typedef struct packed {
    logic [3:0] nib;
    logic [3:0] an;
    logic       ft;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_i = 1'b0;
  logic [15:0] value_i = 16'h0;
  logic        lzb_en_i = 1'b0;
  logic [3:0]  nibble_o;
  logic [3:0]  anode_n_o;
  logic        frame_tick_o;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   slot = 0;
  bit   stim_done = 1'b0;

  seg_digit_scanner #(.REFRESH_DIV(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (load_i),
    .value_i      (value_i),
    .lzb_en_i     (lzb_en_i),
    .nibble_o     (nibble_o),
    .anode_n_o    (anode_n_o),
    .frame_tick_o (frame_tick_o)
  );

  always #5 clk = ~clk;

  // One stimulus slot: drive just after the edge, queue what must be seen this cycle.
  task automatic cyc(input logic rst, input logic ld, input logic [15:0] v,
                     input logic lz, input exp_t e);
    @(posedge clk);
    #1;
    rst_n    = rst;
    load_i   = ld;
    value_i  = ld ? v : 16'($urandom);
    lzb_en_i = lz;
    exp_q.push_back(e);
    slot++;
  endtask

  // n cycles of a frame whose displayed value is hand-given as sh; up to two loads.
  task automatic frame(input logic [15:0] sh, input logic lz,
                       input int l1c, input logic [15:0] l1v,
                       input int l2c, input logic [15:0] l2v, input int n);
    int          d;
    logic        ld;
    logic [15:0] v;
    logic [3:0]  one;
    logic        blank;
    exp_t        e;
    one = 4'b0001;
    for (int c = 0; c < n; c++) begin
      d  = c / 4;
      ld = 1'b0;
      v  = 16'h0;
      if (c == l1c) begin ld = 1'b1; v = l1v; end
      if (c == l2c) begin ld = 1'b1; v = l2v; end
      blank = lz && (d != 0) && ((sh >> (4 * d)) == 16'h0);
      e.nib = sh[4*d +: 4];
      e.an  = blank ? 4'b1111 : ~(one << d);
      e.ft  = (c == 15);
      cyc(1'b1, ld, v, lz, e);
    end
  endtask

  localparam exp_t RST_EXP = '{nib: 4'h0, an: 4'b1110, ft: 1'b0};

  initial begin : stimulus
    // Held in reset
    cyc(1'b0, 1'b0, 16'h0, 1'b0, RST_EXP);
    cyc(1'b0, 1'b1, 16'hBEEF, 1'b1, RST_EXP);
    cyc(1'b0, 1'b0, 16'h0, 1'b0, RST_EXP);
    // F0: blank display, load 1234 at cycle 2
    frame(16'h0000, 1'b0, 2, 16'h1234, -1, 16'h0, 16);
    // F1: show 1234; ABCD pends, then 5678 collides with the boundary
    frame(16'h1234, 1'b0, 5, 16'hABCD, 15, 16'h5678, 16);
    frame(16'hABCD, 1'b0, -1, 16'h0, -1, 16'h0, 16);
    // F3: 5678; load 0070 one cycle before the boundary
    frame(16'h5678, 1'b0, 14, 16'h0070, -1, 16'h0, 16);
    // F4: 0070 with blanking; 0000 loaded on the boundary with nothing pending
    frame(16'h0070, 1'b1, 15, 16'h0000, -1, 16'h0, 16);
    frame(16'h0070, 1'b0, -1, 16'h0, -1, 16'h0, 16);
    // F6: 0000 blanked to a single digit; two loads, last wins
    frame(16'h0000, 1'b1, 3, 16'h1111, 9, 16'h2222, 16);
    frame(16'h2222, 1'b0, 1, 16'hFFFF, -1, 16'h0, 16);
    // F8: FFFF up to digit 2, a pending load, then a reset pulse
    frame(16'hFFFF, 1'b0, 5, 16'h9999, -1, 16'h0, 9);
    cyc(1'b0, 1'b0, 16'h0, 1'b0, RST_EXP);
    frame(16'h0000, 1'b0, -1, 16'h0, -1, 16'h0, 16);
    frame(16'h0000, 1'b0, -1, 16'h0, -1, 16'h0, 16);
    stim_done = 1'b1;
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (nibble_o !== e.nib || anode_n_o !== e.an || frame_tick_o !== e.ft) begin
          failures++;
          $display("FAIL out_slot%0d: got nib=%h an=%b ft=%b, want nib=%h an=%b ft=%b",
                   checks, nibble_o, anode_n_o, frame_tick_o, e.nib, e.an, e.ft);
        end
      end
    end
  end

  initial begin : finisher
    int budget;
    budget = 0;
    while (!stim_done && budget < 2000) begin
      @(posedge clk);
      budget++;
    end
    if (!stim_done) begin
      failures++;
      $display("FAIL stim_timeout: got slots=%0d, want completion", slot);
    end
    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d left in queue, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
